// File: rtl/message_unpadder.sv
// Strips SHA-256 padding from one 512-bit block streamed in as 16 words and re-emits the message words.
// Define UNPADDER_CHECK_EN to also validate the 1-marker bit and the zero field that follows it.
module message_unpadder #(
   parameter int PADDED_BITS = 512,
   parameter int WORD_BITS   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WORD_BITS-1:0] in_word,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_BITS-1:0] out_word,
   output logic [3:0]           out_keep,
   output logic                 out_last,
   output logic [8:0]           msg_len,
   output logic                 done,
   output logic                 err
);
   localparam int NUM_WORDS = PADDED_BITS / WORD_BITS;
   // Longest message that still leaves room for the marker byte and the 64-bit length.
   localparam int MAX_LEN   = PADDED_BITS - 72;

   typedef enum logic [1:0] {COLLECT, CHECK, EMIT, ERROR} state_t;

   state_t               state;
   logic [3:0]           in_cnt;
   logic [3:0]           emit_idx;
   logic [3:0]           last_idx;
   logic [WORD_BITS-1:0] buffer [NUM_WORDS];

   logic [8:0]           len_c;
   logic [8:0]           len_m1;
   logic [3:0]           last_c;
   logic [3:0]           emit_next;
   logic                 len_ok;
   logic                 blk_ok;
   logic [3:0]           word_sel;
   logic                 sel_is_last;
   logic [3:0]           keep_sel;
   logic [WORD_BITS-1:0] word_sel_masked;

   // Bytes kept in the final word, MSB byte first; a whole word is kept when L is a multiple of 32.
   function automatic logic [3:0] keep_of(input logic [8:0] len);
      case (len[4:3])
         2'd1:    keep_of = 4'b1000;
         2'd2:    keep_of = 4'b1100;
         2'd3:    keep_of = 4'b1110;
         default: keep_of = 4'b1111;
      endcase
   endfunction

   function automatic logic [WORD_BITS-1:0] mask_word(input logic [WORD_BITS-1:0] w,
                                                      input logic [3:0] keep);
      for (int b = 0; b < 4; b++)
         mask_word[b*8 +: 8] = keep[b] ? w[b*8 +: 8] : 8'h00;
   endfunction

   assign in_ready  = (state == COLLECT) && !rst;
   assign len_c     = buffer[NUM_WORDS-1][8:0];
   assign len_m1    = len_c - 9'd1;
   assign last_c    = 4'(len_m1 >> 5);
   assign emit_next = emit_idx + 4'd1;
   assign len_ok    = (buffer[NUM_WORDS-2] == '0) &&
                      (buffer[NUM_WORDS-1] <= WORD_BITS'(MAX_LEN)) &&
                      (buffer[NUM_WORDS-1][2:0] == 3'd0);

`ifdef UNPADDER_CHECK_EN
   logic pad_ok;

   always_comb begin
      pad_ok = 1'b1;
      for (int i = 64; i < PADDED_BITS; i++) begin
         if (i == PADDED_BITS - 1 - int'(len_c)) begin
            if (!buffer[(PADDED_BITS-1-i)/WORD_BITS][i%WORD_BITS]) pad_ok = 1'b0;
         end else if (i < PADDED_BITS - 1 - int'(len_c)) begin
            if (buffer[(PADDED_BITS-1-i)/WORD_BITS][i%WORD_BITS]) pad_ok = 1'b0;
         end
      end
   end

   assign blk_ok = len_ok && pad_ok;
`else
   assign blk_ok = len_ok;
`endif

   // Next beat to present: word 0 when leaving CHECK, otherwise the word after the one just taken.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      word_sel    = 4'd0;
      sel_is_last = 1'b0;
      keep_sel    = 4'b1111;
      if (state == CHECK) begin
         sel_is_last = (last_c == 4'd0);
         if (sel_is_last) keep_sel = keep_of(len_c);
      end else begin
         word_sel    = emit_next;
         sel_is_last = (emit_next == last_idx);
         if (sel_is_last) keep_sel = keep_of(msg_len);
      end
      word_sel_masked = mask_word(buffer[word_sel], keep_sel);
   end

   // NOTE: the block buffer is plain storage with no reset; the FSM never reads stale words.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) buffer[in_cnt] <= in_word;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= COLLECT;
         in_cnt    <= 4'd0;
         emit_idx  <= 4'd0;
         last_idx  <= 4'd0;
         out_valid <= 1'b0;
         out_word  <= '0;
         out_keep  <= 4'd0;
         out_last  <= 1'b0;
         msg_len   <= 9'd0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            COLLECT: begin
               if (in_valid) begin
                  if (in_cnt == 4'd0) msg_len <= 9'd0;
                  in_cnt <= in_cnt + 4'd1;
                  if (in_cnt == 4'(NUM_WORDS-1)) state <= CHECK;
               end
            end
            CHECK: begin
               if (!blk_ok) begin
                  err     <= 1'b1;
                  msg_len <= 9'd0;
                  state   <= ERROR;
               end else if (len_c == 9'd0) begin
                  msg_len <= 9'd0;
                  done    <= 1'b1;
                  state   <= COLLECT;
               end else begin
                  msg_len   <= len_c;
                  last_idx  <= last_c;
                  emit_idx  <= 4'd0;
                  out_valid <= 1'b1;
                  out_word  <= word_sel_masked;
                  out_keep  <= keep_sel;
                  out_last  <= sel_is_last;
                  state     <= EMIT;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_word  <= '0;
                     out_keep  <= 4'd0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= COLLECT;
                  end else begin
                     emit_idx <= emit_next;
                     out_word <= word_sel_masked;
                     out_keep <= keep_sel;
                     out_last <= sel_is_last;
                  end
               end
            end
            ERROR:   state <= COLLECT;
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_message_unpadder.sv
// Self-checking bench for message_unpadder: a block-level model predicts beats and done/err events,
// one negedge monitor compares every cycle, and directed blocks pin the model with literal values.
module tb_message_unpadder;
   typedef logic [31:0] blk_t [16];
   typedef struct packed {logic [31:0] word; logic [3:0] keep; logic last;} beat_t;
   typedef struct packed {logic is_err; logic [8:0] len;} evt_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_word = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_word;
   logic [3:0]  out_keep;
   logic        out_last;
   logic [8:0]  msg_len;
   logic        done;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   beat_t       exp_q[$];
   evt_t        evt_q[$];
   logic [31:0] got_word[$];
   logic [3:0]  got_keep[$];
   logic        got_last[$];
   int          evt_cnt = 0;
   int          evt_base = 0;
   evt_t        last_evt = '0;
   logic        lat_pending = 1'b0;
   time         last_in_t = 0;
   logic        prev_stall = 1'b0;
   beat_t       prev_beat = '0;

   message_unpadder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_keep  (out_keep),
      .out_last  (out_last),
      .msg_len   (msg_len),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Block-level model: decide accept/reject from the padding rules, then list the beats.
   task automatic model_block(input blk_t b);
      logic [511:0] flat;
      bit           ok;
      int           len;
      int           nw;
      int           nb;
      beat_t        e;
      evt_t         ev;
      for (int w = 0; w < 16; w++) flat[511-32*w -: 32] = b[w];
      ok  = (b[14] == 32'd0) && (b[15] <= 32'd440) && (b[15] % 8 == 0);
      len = ok ? int'(b[15]) : 0;
`ifdef UNPADDER_CHECK_EN
      if (ok) begin
         if (flat[511-len] != 1'b1) ok = 0;
         for (int i = 64; i < 511 - len; i++) if (flat[i]) ok = 0;
      end
`endif
      if (!ok) begin
         ev.is_err = 1'b1;
         ev.len    = 9'd0;
      end else begin
         nw = (len + 31) / 32;
         nb = (len / 8) % 4;
         for (int k = 0; k < nw; k++) begin
            e.word = b[k];
            e.last = (k == nw - 1);
            e.keep = 4'hF;
            if (e.last && nb != 0) e.keep = 4'(4'hF << (4 - nb));
            for (int j = 0; j < 4; j++) if (!e.keep[j]) e.word[j*8 +: 8] = 8'h00;
            exp_q.push_back(e);
         end
         ev.is_err = 1'b0;
         ev.len    = len[8:0];
      end
      evt_q.push_back(ev);
   endtask

   always @(negedge clk) begin
      beat_t e;
      evt_t  ev;
      if (rst) begin
         check("reset_outputs",
               {out_valid, out_last, done, err, in_ready, out_keep, out_word, msg_len}, 64'd0);
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_beat_held", {out_word, out_keep, out_last}, prev_beat);
         end
         if (lat_pending && (out_valid || done || err)) begin
            check("latency", $time - last_in_t, 15);
            lat_pending = 1'b0;
         end
         if (out_valid) check("in_ready_low_while_emitting", in_ready, 0);
         if (out_valid && out_ready) begin
            got_word.push_back(out_word);
            got_keep.push_back(out_keep);
            got_last.push_back(out_last);
            if (exp_q.size() == 0) check("beat_expected", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               check("beat", {out_word, out_keep, out_last}, e);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_beat  = {out_word, out_keep, out_last};
         if (done || err) begin
            check("done_err_exclusive", done && err, 0);
            evt_cnt++;
            last_evt = {err, msg_len};
            if (evt_q.size() == 0) check("event_expected", evt_q.size(), 1);
            else begin
               ev = evt_q.pop_front();
               check("event", {err, msg_len}, ev);
            end
         end
      end
   end

   task automatic send_block(input blk_t b, input bit gaps);
      int   i = 0;
      int   guard = 0;
      logic acc;
      model_block(b);
      while (i < 16 && guard < 400) begin
         in_valid = !(gaps && (guard % 3 == 1));
         in_word  = b[i];
         @(negedge clk);
         acc = in_ready && in_valid;
         @(posedge clk);
         if (acc) begin
            i++;
            if (i == 16) begin
               last_in_t   = $time;
               lat_pending = 1'b1;
            end
         end
         #1;
         guard++;
      end
      in_valid = 1'b0;
      check("send_all_words", i, 16);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || evt_q.size() != 0 || out_valid) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("drain", exp_q.size() + evt_q.size(), 0);
   endtask

   task automatic wait_word(input logic [31:0] w);
      bit found = 0;
      for (int n = 0; n < 50 && !found; n++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_word == w) found = 1;
      end
      check("wait_word_seen", found, 1);
   endtask

   task automatic clear_got();
      got_word.delete();
      got_keep.delete();
      got_last.delete();
      evt_base = evt_cnt;
   endtask

   blk_t b023, b024, b025, b8, bad447, bad14, bad448, nomark;

   initial begin
      b023 = '{default: 32'd0};
      b023[0] = 32'h61626364; b023[1] = 32'h65666768; b023[2] = 32'h696A6B6C;
      b023[3] = 32'h80000000; b023[15] = 32'h60;
      b024 = '{default: 32'd0};
      b024[0] = 32'h80000000;
      b025 = '{default: 32'd0};
      for (int k = 0; k < 13; k++) b025[k] = 32'h10203040 + k;
      b025[13] = 32'hAABBCC80; b025[15] = 32'h1B8;
      b8 = '{default: 32'd0};
      b8[0] = 32'h41800000; b8[15] = 32'd8;
      bad447 = b023; bad447[15] = 32'h1BF;
      bad14  = b023; bad14[14]  = 32'd1;
      bad448 = b023; bad448[15] = 32'h1C0;
      nomark = b023; nomark[3]  = 32'd0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1);
      @(posedge clk);
      #1;

      // Three full words, 96 bits.
      clear_got();
      send_block(b023, 0);
      wait_idle();
      check("b023_count", got_word.size(), 3);
      check("b023_w0", got_word[0], 32'h61626364);
      check("b023_w1", got_word[1], 32'h65666768);
      check("b023_w2", got_word[2], 32'h696A6B6C);
      check("b023_keep2", got_keep[2], 4'b1111);
      check("b023_last", {got_last[0], got_last[1], got_last[2]}, 3'b001);
      check("b023_events", evt_cnt - evt_base, 1);
      check("b023_evt", last_evt, {1'b0, 9'd96});
      check("b023_msg_len_held", msg_len, 96);

      // Empty message then a gappy block straight after.
      clear_got();
      send_block(b024, 0);
      wait_idle();
      check("b024_count", got_word.size(), 0);
      check("b024_evt", last_evt, {1'b0, 9'd0});
      check("b024_events", evt_cnt - evt_base, 1);
      clear_got();
      send_block(b023, 1);
      wait_idle();
      check("gappy_count", got_word.size(), 3);

      // Maximum length: 440 bits, last word keeps three bytes.
      clear_got();
      send_block(b025, 0);
      wait_idle();
      check("b025_count", got_word.size(), 14);
      check("b025_last_word", got_word[13], 32'hAABBCC00);
      check("b025_last_keep", got_keep[13], 4'b1110);
      check("b025_last_flag", got_last[13], 1);
      check("b025_evt", last_evt, {1'b0, 9'd440});

      // Single byte.
      clear_got();
      send_block(b8, 0);
      wait_idle();
      check("b8_word", got_word[0], 32'h41000000);
      check("b8_keep", got_keep[0], 4'b1000);

      // Length violations.
      clear_got();
      send_block(bad447, 0);
      wait_idle();
      send_block(bad14, 0);
      wait_idle();
      send_block(bad448, 0);
      wait_idle();
      check("bad_count", got_word.size(), 0);
      check("bad_events", evt_cnt - evt_base, 3);
      check("bad_last_evt", last_evt, {1'b1, 9'd0});

      // Missing marker byte.
      clear_got();
      send_block(nomark, 0);
      wait_idle();
`ifdef UNPADDER_CHECK_EN
      check("nomark_count", got_word.size(), 0);
      check("nomark_evt", last_evt, {1'b1, 9'd0});
`else
      check("nomark_count", got_word.size(), 3);
      check("nomark_evt", last_evt, {1'b0, 9'd96});
`endif

      // Backpressure on the second word.
      clear_got();
      send_block(b023, 0);
      wait_word(32'h65666768);
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("stalled_word", out_word, 32'h65666768);
      @(posedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle();
      check("bp_count", got_word.size(), 3);
      check("bp_w1", got_word[1], 32'h65666768);

      // Reset while the second word is pending.
      clear_got();
      send_block(b023, 0);
      wait_word(32'h65666768);
      out_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      evt_q.delete();
      lat_pending = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("in_ready_after_mid_reset", in_ready, 1);
      repeat (20) @(posedge clk);
      #1;
      check("rst_no_events", evt_cnt - evt_base, 0);
      check("rst_beats", got_word.size(), 1);
      clear_got();
      send_block(b023, 0);
      wait_idle();
      check("post_rst_count", got_word.size(), 3);
      check("post_rst_evt", last_evt, {1'b0, 9'd96});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/message_unpadder.md
MESSAGE_UNPADDER -- requirements
Module: message_unpadder

Interface
REQ-001 SHALL have parameter PADDED_BITS, default 512, meaning padded SHA-256 block width (fixed 512; other values unsupported).
REQ-002 SHALL have parameter WORD_BITS, default 32, meaning stream word width (fixed 32).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_word input 32: padded-block words, word 0 = bits 511:480 (MSB first).
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_word output 32, out_keep output 4 (bit3 = MSB byte), out_last output 1: recovered message words.
REQ-007 SHALL have port msg_len  output  9  decoded message bit length, valid from CHECK until next block starts.
REQ-008 SHALL have ports done output 1 (one-cycle pulse, block accepted) and err output 1 (one-cycle pulse, block rejected).

Function
REQ-009 SHALL implement FSM COLLECT -> CHECK -> EMIT|ERROR -> COLLECT; EMIT skipped (direct to COLLECT with done) when L = 0.
REQ-010 COLLECT: in_ready = 1; transfer on in_valid && in_ready; 4-bit counter stores word n into 16x32 buffer; 16th transfer moves to CHECK.
REQ-011 CHECK (exactly 1 cycle, in_ready = 0): L = {word14, word15}; valid iff word14 = 0, word15 <= 440, word15[2:0] = 0, plus REQ-019 checks when enabled.
REQ-012 Valid -> msg_len = L, go EMIT; invalid -> ERROR: err = 1 for one cycle, msg_len = 0, buffer discarded, back to COLLECT.
REQ-013 EMIT: emits ceil(L/32) words, word k = buffer word k; out_keep = 4'b1111 except last word, which keeps ((L/8) mod 4) MSB bytes (0 -> 4'b1111); unkept bytes driven 0.
REQ-014 out_last = 1 only on final emitted word; done pulses the cycle after that word's transfer, FSM returns to COLLECT same cycle.
REQ-015 Latency: 16th input transfer at edge t -> CHECK during cycle t+1 -> first out_valid (or err/done pulse) in cycle t+2.
REQ-016 Backpressure: while out_valid && !out_ready, out_word/out_keep/out_last SHALL hold stable; out_valid never drops without transfer.
REQ-017 in_ready = 0 in CHECK, EMIT, ERROR; no input word lost or accepted outside COLLECT.
REQ-018 Length arithmetic SHALL be unsigned; word14 != 0 is an error regardless of word15 (no truncation).

Reset
REQ-020 rst asserted: FSM -> COLLECT, counter = 0, in_ready = 0 while rst high, out_valid/out_last/done/err = 0, out_word = 0, out_keep = 0, msg_len = 0.
REQ-021 rst mid-COLLECT or mid-EMIT SHALL abandon the block; no partial done/err after release; in_ready = 1 first cycle after release.

Configuration
REQ-019 Macro UNPADDER_CHECK_EN defined: CHECK additionally requires bit (511-L) = 1 and bits (510-L) down to 64 all 0, else ERROR.
REQ-022 UNPADDER_CHECK_EN undefined: marker/zero-field checks omitted (no logic); only REQ-011 length checks produce err.

Verification
REQ-023 Words 0x61626364,0x65666768,0x696A6B6C,0x80000000, eleven 0x0, 0x00000060 -> 3 words out, keep 4'b1111 each, out_last on 3rd, msg_len = 96, done pulse, err = 0.
REQ-024 Word0 = 0x80000000, words 1-15 = 0 -> no out_valid, msg_len = 0, done pulse in cycle t+2.
REQ-025 L = 440 (word15 = 0x1B8), word13 = 0xAABBCC80 -> 14 words, last out_word = 0xAABBCC00, keep 4'b1110, out_last = 1.
REQ-026 word15 = 0x1BF (447) or word14 = 1 -> err pulse t+2, no out_valid; with UNPADDER_CHECK_EN, REQ-023 block with word3 = 0 -> err; without macro -> 3 words emitted.
REQ-027 REQ-023 block with out_ready low 5 cycles on 2nd word -> word held 0x65666768 stable, no drop, then completes; rst during 2nd word -> outputs 0, next block processed normally.
